// File: rtl/avalon_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with alternating priority and an
// in-order read-ID FIFO that steers pipelined read data back to its requester.
module avalon_arbiter #(
  parameter int unsigned NBDATABYTES = 2,
  parameter int unsigned NBADDRBITS  = 8,
  parameter int unsigned MAXPENDING  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    m0_address,
  input  logic [NBDATABYTES-1:0]   m0_byteenable,
  input  logic [8*NBDATABYTES-1:0] m0_writedata,
  input  logic                     m0_read,
  input  logic                     m0_write,
  output logic                     m0_waitrequest,
  output logic [8*NBDATABYTES-1:0] m0_readdata,
  output logic                     m0_readdatavalid,
  input  logic [NBADDRBITS-1:0]    m1_address,
  input  logic [NBDATABYTES-1:0]   m1_byteenable,
  input  logic [8*NBDATABYTES-1:0] m1_writedata,
  input  logic                     m1_read,
  input  logic                     m1_write,
  output logic                     m1_waitrequest,
  output logic [8*NBDATABYTES-1:0] m1_readdata,
  output logic                     m1_readdatavalid,
  output logic [NBADDRBITS-1:0]    av_address,
  output logic [NBDATABYTES-1:0]   av_byteenable,
  output logic [8*NBDATABYTES-1:0] av_writedata,
  output logic                     av_read,
  output logic                     av_write,
  input  logic                     av_waitrequest,
  input  logic [8*NBDATABYTES-1:0] av_readdata,
  input  logic                     av_readdatavalid
);

  localparam int unsigned PW = (MAXPENDING > 1) ? $clog2(MAXPENDING) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {StIdle, StBusy} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_prio;
  logic [MAXPENDING-1:0] r_fifo;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic w_busy, w_own_read, w_own_write, w_room, w_elig0, w_elig1;
  logic w_accept, w_push, w_pop, w_pop_id;

  // Outputs are gated by rst so a synchronous reset mid-transfer is quiet at once.
  assign w_busy      = (r_state == StBusy) && !rst;
  assign w_own_read  = r_owner ? m1_read : m0_read;
  assign w_own_write = r_owner ? m1_write : m0_write;
  assign w_room      = r_count < CW'(MAXPENDING);
  assign w_elig0     = m0_write || (m0_read && w_room);
  assign w_elig1     = m1_write || (m1_read && w_room);

  assign av_address    = r_owner ? m1_address : m0_address;
  assign av_byteenable = r_owner ? m1_byteenable : m0_byteenable;
  assign av_writedata  = r_owner ? m1_writedata : m0_writedata;
  // A simultaneous read+write from the owner is forwarded as a read only.
  assign av_read       = w_busy && w_own_read;
  assign av_write      = w_busy && w_own_write && !w_own_read;

  assign m0_waitrequest = (w_busy && !r_owner) ? av_waitrequest : 1'b1;
  assign m1_waitrequest = (w_busy && r_owner) ? av_waitrequest : 1'b1;

  assign w_accept = w_busy && (av_read || av_write) && !av_waitrequest;
  assign w_push   = w_accept && av_read;
  assign w_pop    = av_readdatavalid && (r_count != '0) && !rst;
  assign w_pop_id = r_fifo[r_rptr];

  assign m0_readdatavalid = w_pop && !w_pop_id;
  assign m1_readdatavalid = w_pop && w_pop_id;
  assign m0_readdata      = av_readdata;
  assign m1_readdata      = av_readdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_elig0 || w_elig1) begin
            r_owner <= (w_elig0 && w_elig1) ? r_prio : w_elig1;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (w_accept) begin
            r_prio  <= ~r_owner;
            r_state <= StIdle;
          end else if (!w_own_read && !w_own_write) begin
            r_state <= StIdle;
          end
        end
      endcase

      if (w_push) begin
        r_fifo[r_wptr] <= r_owner;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: cycle vector table for arbitration, plus a
// read-ID scoreboard for response routing, reset discard and the pending limit.
module tb_avalon_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  m0_address, m1_address, av_address;
  logic [1:0]  m0_byteenable, m1_byteenable, av_byteenable;
  logic [15:0] m0_writedata, m1_writedata, av_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata, av_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        av_read, av_write, av_waitrequest, av_readdatavalid;

  int checks = 0;
  int failures = 0;
  int sb[$];

  avalon_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_writedata     (m0_writedata),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_writedata     (m1_writedata),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .av_address       (av_address),
    .av_byteenable    (av_byteenable),
    .av_writedata     (av_writedata),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // in = {m0_read, m0_write, m1_read, m1_write, av_waitrequest, av_readdatavalid}
  // ex = {av_read, av_write, m0_waitrequest, m1_waitrequest, m0_rdv, m1_rdv}
  typedef struct {
    logic [5:0]  in;
    logic [5:0]  ex;
    logic        chk;
    logic [7:0]  eaddr;
    logic [1:0]  ebe;
    logic [15:0] ewd;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [5:0] ex,
                              input logic chk, input logic own);
    vec_t v;
    v.in    = in;
    v.ex    = ex;
    v.chk   = chk;
    v.eaddr = own ? 8'h34 : 8'h12;
    v.ebe   = own ? 2'b10 : 2'b11;
    v.ewd   = own ? 16'h1111 : 16'hBEEF;
    return v;
  endfunction

  task automatic issue_read(input int id);
    bit ok;
    ok = 1'b0;
    if (id == 0) m0_read = 1'b1; else m1_read = 1'b1;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (((id == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) ok = 1'b1;
      @(posedge clk); #1;
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL read_grant m%0d: waitrequest never low, required grant within 8 cycles", id);
    end else begin
      sb.push_back(id);
    end
  endtask

  task automatic resp(input logic [15:0] d);
    logic [1:0] exp_v;
    int id;
    av_readdatavalid = 1'b1;
    av_readdata      = d;
    @(negedge clk);
    if (sb.size() > 0) begin
      id    = sb.pop_front();
      exp_v = (id == 0) ? 2'b10 : 2'b01;
    end else begin
      exp_v = 2'b00;
    end
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== exp_v || m0_readdata !== d ||
        m1_readdata !== d) begin
      failures++;
      $display("FAIL resp %h: rdv{m0,m1}=%b data=%h/%h, required rdv=%b data=%h",
               d, {m0_readdatavalid, m1_readdatavalid}, m0_readdata, m1_readdata, exp_v, d);
    end
    @(posedge clk); #1;
    av_readdatavalid = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    logic [5:0] act;
    @(negedge clk);
    act = {av_read, av_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
           m1_readdatavalid};
    checks++;
    if (act !== 6'b001100) begin
      failures++;
      $display("FAIL %s: outputs=%b, required 001100", name, act);
    end
  endtask

  vec_t vecs[33];

  initial begin
    vecs[0]  = mk(6'b010000, 6'b001100, 1'b0, 1'b0);
    vecs[1]  = mk(6'b010000, 6'b010100, 1'b1, 1'b0);
    vecs[2]  = mk(6'b000000, 6'b001100, 1'b0, 1'b0);
    vecs[3]  = mk(6'b101000, 6'b001100, 1'b0, 1'b0);
    vecs[4]  = mk(6'b101000, 6'b101000, 1'b1, 1'b1);
    vecs[5]  = mk(6'b101000, 6'b001100, 1'b0, 1'b0);
    vecs[6]  = mk(6'b101000, 6'b100100, 1'b1, 1'b0);
    vecs[7]  = mk(6'b101000, 6'b001100, 1'b0, 1'b0);
    vecs[8]  = mk(6'b101000, 6'b101000, 1'b1, 1'b1);
    vecs[9]  = mk(6'b001000, 6'b001100, 1'b0, 1'b0);
    vecs[10] = mk(6'b101010, 6'b101100, 1'b1, 1'b1);
    vecs[11] = mk(6'b101010, 6'b101100, 1'b1, 1'b1);
    vecs[12] = mk(6'b101010, 6'b101100, 1'b1, 1'b1);
    vecs[13] = mk(6'b101000, 6'b101000, 1'b1, 1'b1);
    vecs[14] = mk(6'b100000, 6'b001100, 1'b0, 1'b0);
    vecs[15] = mk(6'b100100, 6'b001100, 1'b0, 1'b0);
    vecs[16] = mk(6'b100100, 6'b011000, 1'b1, 1'b1);
    vecs[17] = mk(6'b100001, 6'b001101, 1'b0, 1'b0);
    vecs[18] = mk(6'b100000, 6'b001100, 1'b0, 1'b0);
    vecs[19] = mk(6'b100000, 6'b100100, 1'b1, 1'b0);
    vecs[20] = mk(6'b000001, 6'b001110, 1'b0, 1'b0);
    vecs[21] = mk(6'b000001, 6'b001101, 1'b0, 1'b0);
    vecs[22] = mk(6'b000001, 6'b001101, 1'b0, 1'b0);
    vecs[23] = mk(6'b000001, 6'b001110, 1'b0, 1'b0);
    vecs[24] = mk(6'b000001, 6'b001100, 1'b0, 1'b0);
    vecs[25] = mk(6'b110000, 6'b001100, 1'b0, 1'b0);
    vecs[26] = mk(6'b110000, 6'b100100, 1'b1, 1'b0);
    vecs[27] = mk(6'b000001, 6'b001110, 1'b0, 1'b0);
    vecs[28] = mk(6'b000100, 6'b001100, 1'b0, 1'b0);
    vecs[29] = mk(6'b000000, 6'b001000, 1'b0, 1'b0);
    vecs[30] = mk(6'b010100, 6'b001100, 1'b0, 1'b0);
    vecs[31] = mk(6'b010100, 6'b011000, 1'b1, 1'b1);
    vecs[32] = mk(6'b000000, 6'b001100, 1'b0, 1'b0);

    m0_address = 8'h12; m0_byteenable = 2'b11; m0_writedata = 16'hBEEF;
    m1_address = 8'h34; m1_byteenable = 2'b10; m1_writedata = 16'h1111;
    {m0_read, m0_write, m1_read, m1_write} = 4'b0101;
    av_waitrequest = 1'b0; av_readdatavalid = 1'b1; av_readdata = 16'h0;
    rst = 1'b1;

    // Requests and stray responses during reset must stay invisible.
    chk_quiet("reset_cycle0");
    @(posedge clk); #1;
    chk_quiet("reset_cycle1");
    @(posedge clk); #1;
    rst = 1'b0;
    {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
    av_readdatavalid = 1'b0;

    for (int i = 0; i < 33; i++) begin
      logic [5:0]  act;
      logic [15:0] rd;
      bit          ok;
      rd = 16'(16'hC000 + i);
      {m0_read, m0_write, m1_read, m1_write, av_waitrequest, av_readdatavalid} = vecs[i].in;
      av_readdata = rd;
      @(negedge clk);
      act = {av_read, av_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
             m1_readdatavalid};
      ok = (act === vecs[i].ex) && (m0_readdata === rd) && (m1_readdata === rd);
      if (vecs[i].chk)
        ok = ok && (av_address === vecs[i].eaddr) && (av_byteenable === vecs[i].ebe) &&
             (av_writedata === vecs[i].ewd);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL vec%0d: outputs=%b addr=%h be=%b wd=%h rd=%h/%h, required %b addr=%h be=%b wd=%h rd=%h",
                 i, act, av_address, av_byteenable, av_writedata, m0_readdata, m1_readdata,
                 vecs[i].ex, vecs[i].eaddr, vecs[i].ebe, vecs[i].ewd, rd);
      end
      @(posedge clk); #1;
    end
    {m0_read, m0_write, m1_read, m1_write, av_waitrequest, av_readdatavalid} = 6'b0;

    // Responses route back in acceptance order.
    issue_read(0); issue_read(1); issue_read(1); issue_read(0);
    resp(16'h000A); resp(16'h000B); resp(16'h000C); resp(16'h000D);
    resp(16'h000E);

    // Reset in the middle of a write, and with reads outstanding.
    issue_read(0); issue_read(1);
    m0_write = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_quiet("reset_midtransfer");
    @(posedge clk); #1;
    rst = 1'b0;
    m0_write = 1'b0;
    sb.delete();
    resp(16'h00F1); resp(16'h00F2);

    // Fill all pending slots; a fifth read must stall until a slot frees.
    issue_read(0); issue_read(1); issue_read(0); issue_read(1);
    begin
      bit blocked;
      blocked = 1'b1;
      m0_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (!m0_waitrequest || av_read) blocked = 1'b0;
        @(posedge clk); #1;
      end
      checks++;
      if (!blocked) begin
        failures++;
        $display("FAIL pending_limit: read granted with 4 outstanding, required stall");
      end
    end
    resp(16'h0051);
    issue_read(0);
    resp(16'h0052); resp(16'h0053); resp(16'h0054); resp(16'h0055);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d ids left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
